// File: rtl/decrypt_scheduler.sv
// In-place decryption sequencer for the frame BRAM: walks every pixel with read/modify/write
// and shares the single BRAM port with the VGA reader, which always wins the port.
module decrypt_scheduler #(
    parameter int ADDR_W = 15,
    parameter int PIXELS = 30625
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        key,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pixel_idx
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PIXELS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]        key_q, key_d;
    logic [7:0]        data_q, data_d;
    logic              rvalid_q;

    // Pixels whose bits [6:3] are all ones, or equal 0x1C, are replaced by the key.
    function automatic logic [7:0] subst(input logic [7:0] d, input logic [7:0] k);
        return ((d[6:3] == 4'b1111) || (d == 8'h1C)) ? k : d;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            key_q    <= '0;
            data_q   <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            key_q    <= key_d;
            data_q   <= data_d;
            rvalid_q <= vga_req;
        end
    end

    // The VGA address is the default port owner; the engine takes the port only
    // in READ/WRITE when VGA is not requesting and no abort is pending.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        key_d    = key_q;
        data_d   = data_q;
        mem_addr = vga_addr;
        mem_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    key_d   = key;
                    idx_d   = '0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!vga_req) begin
                    mem_addr = idx_q;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                data_d  = mem_rdata;
                state_d = abort ? S_IDLE : S_WRITE;
            end
            S_WRITE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!vga_req) begin
                    mem_addr = idx_q;
                    mem_we   = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_wdata  = subst(data_q, key_q);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign pixel_idx  = idx_q;
    assign vga_rvalid = rvalid_q;

endmodule

// File: tb/tb_decrypt_scheduler.sv
// Scoreboard bench for decrypt_scheduler: a reduced image size keeps passes short while
// exercising pass timing, VGA contention, abort, start-while-busy and async reset.
module tb_decrypt_scheduler;
    localparam int ADDR_W = 15;
    localparam int PIX    = 120;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [7:0]        key = 8'h00;
    logic              vga_req = 1'b0;
    logic [ADDR_W-1:0] vga_addr = '0;
    logic              vga_rvalid;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] pixel_idx;

    logic [7:0]        bram [0:PIX-1];
    logic [7:0]        img  [0:PIX-1];
    logic              load_en = 1'b0;
    logic [ADDR_W-1:0] load_addr = '0;
    logic [7:0]        load_data = 8'h00;
    logic              prev_req;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct packed { logic [ADDR_W-1:0] a; logic [7:0] d; } wr_t;
    typedef struct packed { logic dc; logic [7:0] d; } rd_t;
    wr_t wr_q[$];
    rd_t rd_q[$];
    int  done_q[$];

    decrypt_scheduler #(.ADDR_W(ADDR_W), .PIXELS(PIX)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .key(key),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_rvalid(vga_rvalid),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .pixel_idx(pixel_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port BRAM with one-cycle read latency; load port used only while idle.
    always @(posedge clk) begin
        if (load_en) bram[load_addr] <= load_data;
        else if (mem_we) bram[mem_addr] <= mem_wdata;
        mem_rdata <= bram[mem_addr];
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev_req <= 1'b0;
        else prev_req <= vga_req;
    end

    function automatic logic [7:0] subst(input logic [7:0] d, input logic [7:0] k);
        return ((d[6:3] == 4'b1111) || (d == 8'h1C)) ? k : d;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_empty(input string name);
        total++;
        bad++;
        $display("FAIL %s: got an output with nothing expected (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops the scoreboard queues whenever the DUT presents an output.
    always @(negedge clk) begin
        wr_t w;
        rd_t r;
        if (vga_req) begin
            chk("vga_port_addr", 32'(mem_addr), 32'(vga_addr));
            chk("vga_port_we", 32'(mem_we), 32'(0));
        end
        chk("rvalid_follow", 32'(vga_rvalid), 32'(prev_req));
        if (vga_rvalid) begin
            if (rd_q.size() == 0) fail_empty("rvalid_unexpected");
            else begin
                r = rd_q.pop_front();
                if (!r.dc) chk("vga_data", 32'(mem_rdata), 32'(r.d));
            end
        end
        if (mem_we) begin
            if (wr_q.size() == 0) fail_empty("write_unexpected");
            else begin
                w = wr_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(w.a));
                chk("wr_data", 32'(mem_wdata), 32'(w.d));
            end
        end
        if (done) begin
            if (done_q.size() == 0) fail_empty("done_unexpected");
            else chk("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
            chk("busy_at_done", 32'(busy), 32'(1));
        end
    end

    task automatic preload(input bit fixed);
        logic [7:0] v;
        load_en = 1'b1;
        for (int i = 0; i < PIX; i++) begin
            v = ($urandom_range(3) == 0) ? 8'h1C : 8'($urandom);
            if (fixed && i == 0) v = 8'h78;
            if (fixed && i == 1) v = 8'h1C;
            if (fixed && i == 2) v = 8'h05;
            load_addr = ADDR_W'(i);
            load_data = v;
            img[i]    = v;
            @(posedge clk); #1;
        end
        load_en = 1'b0;
    endtask

    task automatic vga_read(input int a);
        vga_req  = 1'b1;
        vga_addr = ADDR_W'(a);
        rd_q.push_back('{dc: 1'b0, d: img[a]});
        @(posedge clk); #1;
        vga_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_image(input string tag);
        int mism  = 0;
        int first = 0;
        for (int i = PIX - 1; i >= 0; i--) begin
            if (bram[i] !== img[i]) begin
                mism++;
                first = i;
            end
        end
        total++;
        if (mism != 0) begin
            bad++;
            $display("FAIL image_%s: %0d pixels differ, first at %0d got %0h expected %0h",
                     tag, mism, first, bram[first], img[first]);
        end
    endtask

    // mode 0: complete pass; 1: abort in WRITE of stop_px; 2: async reset in WAIT of stop_px.
    // A VGA burst of blen cycles starts in phase bph (0 READ, 1 WAIT, 2 WRITE) of pixel bpx.
    task automatic do_pass(input logic [7:0] k, input int bph, input int bpx, input int blen,
                           input int mode, input int stop_px, input bit busy_start,
                           input bit start_abort);
        int n0, c0, dly, dcyc, last;
        dly  = (blen > 0 && bph != 1) ? blen : 0;
        c0   = 3 * bpx + bph + 1;
        dcyc = 3 * PIX + 1 + dly;
        for (int i = 0; i < PIX; i++) wr_q.push_back('{a: ADDR_W'(i), d: subst(img[i], k)});
        key   = k;
        start = 1'b1;
        abort = start_abort;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        n0    = cyc;
        if (mode == 0) done_q.push_back(n0 + dcyc - 1);
        chk("busy_rise", 32'(busy), 32'(1));
        chk("idx_cleared", 32'(pixel_idx), 32'(0));
        last = PIX;
        for (int c = 1; c <= dcyc; c++) begin
            vga_req = (blen > 0 && c >= c0 && c < c0 + blen);
            if (vga_req) begin
                vga_addr = ADDR_W'($urandom_range(PIX - 1));
                rd_q.push_back('{dc: 1'b1, d: 8'h00});
            end
            if (busy_start) begin
                start = (c == 60);
                key   = (c == 60) ? 8'h00 : k;
            end
            if (mode == 1 && c == 3 * stop_px + 3) begin
                wr_q.delete();
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                chk("abort_to_idle", 32'(busy), 32'(0));
                last = stop_px;
                break;
            end
            if (mode == 2 && c == 3 * stop_px + 2) begin
                #2 reset_n = 1'b0;
                #1;
                chk("async_rst_busy", 32'(busy), 32'(0));
                chk("async_rst_we", 32'(mem_we), 32'(0));
                chk("async_rst_idx", 32'(pixel_idx), 32'(0));
                wr_q.delete();
                @(posedge clk); #1;
                reset_n = 1'b1;
                last = stop_px;
                break;
            end
            @(posedge clk); #1;
        end
        vga_req = 1'b0;
        start   = 1'b0;
        if (mode == 0) begin
            chk("busy_fall", 32'(busy), 32'(0));
            chk("idx_hold", 32'(pixel_idx), 32'(PIX - 1));
        end
        for (int i = 0; i < last; i++) img[i] = subst(img[i], k);
        repeat (5) @(posedge clk);
        #1;
        chk("done_pending", 32'(done_q.size()), 32'(0));
        done_q.delete();
        chk("writes_pending", 32'(wr_q.size()), 32'(0));
        wr_q.delete();
        check_image($sformatf("mode%0d", mode));
        for (int j = 0; j < 3; j++) vga_read($urandom_range(PIX - 1));
        chk("reads_pending", 32'(rd_q.size()), 32'(0));
        rd_q.delete();
    endtask

    initial begin
        logic [7:0] rk;
        int ph;
        vga_addr = ADDR_W'(37);
        #1 reset_n = 1'b0;
        #2;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_rvalid", 32'(vga_rvalid), 32'(0));
        chk("rst_idx", 32'(pixel_idx), 32'(0));
        chk("rst_we", 32'(mem_we), 32'(0));
        chk("rst_addr", 32'(mem_addr), 32'(vga_addr));
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_busy", 32'(busy), 32'(0));

        preload(1'b1);
        vga_read(0);
        do_pass(8'hA5, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        chk("pix0", 32'(bram[0]), 32'(8'hA5));
        chk("pix1", 32'(bram[1]), 32'(8'hA5));
        chk("pix2", 32'(bram[2]), 32'(8'h05));

        preload(1'b0);
        do_pass(8'hA5, 0, 5, 10, 0, 0, 1'b0, 1'b0);
        do_pass(8'h3C, 2, 7, 10, 0, 0, 1'b0, 1'b0);
        preload(1'b0);
        do_pass(8'hA5, 0, 0, 0, 0, 0, 1'b1, 1'b0);
        preload(1'b0);
        do_pass(8'h5A, 0, 0, 0, 1, 100, 1'b0, 1'b0);
        do_pass(8'h77, 0, 0, 0, 0, 0, 1'b0, 1'b1);
        preload(1'b0);
        do_pass(8'hC3, 0, 0, 0, 2, 30, 1'b0, 1'b0);
        do_pass(8'h81, 1, 40, 1, 0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 5; n++) begin
            preload(1'b0);
            rk = 8'($urandom);
            ph = $urandom_range(2);
            do_pass(rk, ph, $urandom_range(PIX - 1), (ph == 1) ? 1 : $urandom_range(1, 12),
                    0, 0, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decrypt_scheduler.md
# decrypt_scheduler

Sequences in-place decryption of the 175x175 8-bit image held in the single-port frame BRAM and shares that port with the VGA pixel reader. On `start` it walks every pixel address with read/modify/write, applying the key substitution rule. The VGA reader always has priority, so the display never tears. It sits between the image BRAM, the VGA timing/fetch logic and the top-level control FSM.

## Interface
- `ADDR_W`, 15: BRAM address width.
- `PIXELS`, 30625: pixels per pass (175*175); addresses 0..PIXELS-1.
- `clk` in 1: system clock, all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: level sampled in IDLE only; begins one decryption pass.
- `abort` in 1: cancels a pass in progress.
- `key` in 8: substitution key, latched on accepted `start`.
- `vga_req` in 1: VGA needs the BRAM port this cycle.
- `vga_addr` in ADDR_W: VGA read address.
- `vga_rvalid` out 1: `mem_rdata` holds VGA data (the `vga_req` accepted last cycle).
- `mem_addr` out ADDR_W: BRAM address (combinational mux).
- `mem_we` out 1: BRAM write enable (combinational).
- `mem_wdata` out 8: BRAM write data.
- `mem_rdata` in 8: BRAM read data, 1-cycle latency.
- `busy` out 1: pass in progress (state not IDLE).
- `done` out 1: one-cycle pulse, pass completed.
- `pixel_idx` out ADDR_W: current pixel pointer.

## Operation
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE
  - `start=1` latches `key` into `key_r`, clears `pixel_idx` to 0 and moves to READ.
  - `start` in any other state is ignored.
- READ
  - If `vga_req=1`: stall in READ.
  - Otherwise: drive `mem_addr=pixel_idx`, `mem_we=0`, and move to WAIT.
- WAIT
  - Capture `mem_rdata` into `data_r` unconditionally, then move to WRITE.
  - The port is free for VGA in this cycle.
- WRITE
  - If `vga_req=1`: stall in WRITE.
  - Otherwise: drive `mem_addr=pixel_idx`, `mem_we=1`, `mem_wdata=subst(data_r)`.
  - If `pixel_idx==PIXELS-1`, move to DONE; else increment `pixel_idx` and return to READ.
- DONE: assert `done` for one cycle, then move to IDLE.
  - `pixel_idx` holds PIXELS-1 until the next `start`.
- Substitution rule: `subst(d) = key_r` if `d[6:3]==4'b1111` or `d==8'h1C`; otherwise `d`.
- Port mux
  - `vga_req=1`: `mem_addr=vga_addr`, `mem_we=0`, in every state.
  - Else in READ/WRITE: engine drives the port as above.
  - Else (idle port): `mem_addr=vga_addr`, `mem_we=0`.
- `mem_wdata` is `subst(data_r)` at all times; it is only meaningful when `mem_we=1`.
- `abort=1` in READ/WAIT/WRITE
  - Next state is IDLE.
  - `mem_we` is forced 0 that cycle.
  - No `done` pulse; pixels already written stay written.
- `abort` has priority over a pending WRITE; it is ignored in IDLE/DONE.
- Arithmetic: `pixel_idx` is an unsigned ADDR_W counter and never exceeds PIXELS-1 (no wrap).

## Timing
- Reset values: `busy=0`, `done=0`, `vga_rvalid=0`, `pixel_idx=0`, `key_r=0`, `data_r=0`, state IDLE.
  - Hence `mem_we=0` and `mem_addr=vga_addr` during reset.
- `vga_rvalid` is `vga_req` registered one cycle; VGA data is never delayed by the engine.
- Uncontended throughput: 3 cycles/pixel.
  - A full pass takes 3*PIXELS = 91875 cycles from the `start` edge to DONE entry.
  - `done` is high in cycle 91876.
- Each stall cycle (`vga_req=1` in READ or WRITE) adds exactly one cycle.
- `busy` rises the cycle after `start` is accepted and falls the cycle after DONE.
- Simultaneous `start` and `abort` in IDLE: `start` wins.
- `reset_n` low mid-pass returns to IDLE immediately (async); partially written data stays in BRAM.

## Test plan
- Reset, idle port: hold `reset_n=0`, then release; `vga_req=0`.
  - Required: all outputs at reset values, `mem_we` never 1, `busy=0`.
- Single full pass, no VGA: preload pixel0=8'h78, pixel1=8'h1C, pixel2=8'h05; `key=8'hA5`; pulse `start`.
  - Required: BRAM ends with 8'hA5, 8'hA5, 8'h05 at addresses 0..2.
  - Required: `done` pulses in cycle 91876, `busy` then drops.
- VGA contention: assert `vga_req` continuously for 10 cycles during READ, and separately during WRITE.
  - Required: `mem_we=0` and `mem_addr=vga_addr` throughout those cycles.
  - Required: `vga_rvalid` follows `vga_req` by 1 cycle, and completion is delayed by exactly 10 cycles each time.
- Abort: assert `abort` in WRITE of pixel 100.
  - Required: no write to address 100, state IDLE next cycle, no `done` pulse.
  - Required: a new `start` restarts from `pixel_idx=0`.
- Start while busy: pulse `start` with `key=8'h00` mid-pass.
  - Required: ignored; `key_r` stays 8'hA5 and the pass continues unchanged.
- Async reset mid-pass: pull `reset_n` low between clock edges in WAIT.
  - Required: `busy=0` and `mem_we=0` immediately, without waiting for a clock edge.
